// File: rtl/k007232_pkg.sv
// Shared types and constants for the 007232 host-side register writer.
// Register indices are chip register numbers; ab_enc maps them onto the AB pins.
package k007232_pkg;

  typedef enum logic [1:0] {
    OP_PLAY    = 2'd0,
    OP_VOLUME  = 2'd1,
    OP_LOOPCFG = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  localparam logic [3:0] REG_PRE_LO_A   = 4'd0;
  localparam logic [3:0] REG_PRE_HI_A   = 4'd1;
  localparam logic [3:0] REG_ADDR_LO_A  = 4'd2;
  localparam logic [3:0] REG_ADDR_MID_A = 4'd3;
  localparam logic [3:0] REG_ADDR_HI_A  = 4'd4;
  localparam logic [3:0] REG_TRIG_A     = 4'd5;
  localparam logic [3:0] REG_PRE_LO_B   = 4'd6;
  localparam logic [3:0] REG_PRE_HI_B   = 4'd7;
  localparam logic [3:0] REG_ADDR_LO_B  = 4'd8;
  localparam logic [3:0] REG_ADDR_MID_B = 4'd9;
  localparam logic [3:0] REG_ADDR_HI_B  = 4'd10;
  localparam logic [3:0] REG_TRIG_B     = 4'd11;
  localparam logic [3:0] REG_VOL        = 4'd12;
  localparam logic [3:0] REG_LOOP       = 4'd13;
  localparam logic [3:0] REG_NONE       = 4'd14;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_SETUP,
    BUS_STROBE,
    BUS_HOLD
  } bus_state_e;

  typedef enum logic [1:0] {
    TOP_IDLE,
    TOP_RUN,
    TOP_NOP
  } top_state_e;

  typedef struct packed {
    op_e         op;
    logic        ch;
    logic [16:0] addr;
    logic [11:0] pre;
    logic [1:0]  mode;
    logic        loop;
    logic [7:0]  vol;
  } cmd_t;

  function automatic logic [3:0] ab_enc(input logic [3:0] n);
    return {n[3:1], ~n[0]};
  endfunction

endpackage

// File: rtl/k007232_bus_cycle.sv
// Single register write engine: SETUP -> STROBE (DACS low) -> HOLD, timed in ce ticks.
// A start in the final HOLD tick chains straight into the next SETUP with no idle gap.
module k007232_bus_cycle
  import k007232_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       nres,
  input  logic       ce,
  input  logic       start,
  input  logic [3:0] reg_idx,
  input  logic [7:0] data,
  output logic       done,
  output logic       dacs,
  output logic [3:0] ab,
  output logic [7:0] db_out,
  output logic       db_oe
);

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

  bus_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] ab_q, ab_d;
  logic [7:0] db_q, db_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    db_d    = db_q;
    done    = 1'b0;
    case (state_q)
      BUS_SETUP: if (ce) begin
        if (cnt_q == SETUP_LAST) begin
          state_d = BUS_STROBE;
          cnt_d   = 8'd0;
        end else cnt_d = cnt_q + 8'd1;
      end
      BUS_STROBE: if (ce) begin
        if (cnt_q == STROBE_LAST) begin
          state_d = BUS_HOLD;
          cnt_d   = 8'd0;
        end else cnt_d = cnt_q + 8'd1;
      end
      BUS_HOLD: if (ce) begin
        if (cnt_q == HOLD_LAST) begin
          done    = 1'b1;
          state_d = BUS_IDLE;
          cnt_d   = 8'd0;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = BUS_IDLE;
    endcase
    // Address and data are latched at start so they stay put through STROBE and HOLD.
    if (start) begin
      state_d = BUS_SETUP;
      cnt_d   = 8'd0;
      ab_d    = ab_enc(reg_idx);
      db_d    = data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nres) begin
      state_q <= BUS_IDLE;
      cnt_q   <= 8'd0;
      ab_q    <= 4'hF;
      db_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      db_q    <= db_d;
    end
  end

  assign dacs   = (state_q != BUS_STROBE);
  assign ab     = (state_q == BUS_IDLE) ? 4'hF : ab_q;
  assign db_out = (state_q == BUS_IDLE) ? 8'h00 : db_q;
  assign db_oe  = (state_q != BUS_IDLE);

endmodule

// File: rtl/k007232_host_writer.sv
// Command front end for the 007232: captures a command, walks its register write list
// through the bus-cycle engine and keeps the per-channel loop shadow for reg13.
module k007232_host_writer
  import k007232_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        CLK,
  input  logic        NRES,
  input  logic        ce,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_ch,
  input  logic [16:0] cmd_addr,
  input  logic [11:0] cmd_pre,
  input  logic [1:0]  cmd_mode,
  input  logic        cmd_loop,
  input  logic [7:0]  cmd_vol,
  output logic        DACS,
  output logic [3:0]  AB,
  output logic [7:0]  DB_OUT,
  output logic        DB_OE,
  output logic        busy
);

  function automatic logic [3:0] step_reg(input cmd_t c, input logic [2:0] step);
    logic [3:0] base;
    base = c.ch ? REG_PRE_LO_B : REG_PRE_LO_A;
    case (c.op)
      OP_PLAY: begin
        case (step)
          3'd5:    return REG_LOOP;
          3'd6:    return base + 4'd5;
          default: return base + {1'b0, step};
        endcase
      end
      OP_VOLUME:  return REG_VOL;
      OP_LOOPCFG: return REG_LOOP;
      default:    return REG_NONE;
    endcase
  endfunction

  function automatic logic [7:0] step_data(input cmd_t c, input logic [2:0] step,
                                           input logic [1:0] shadow);
    case (c.op)
      OP_PLAY: begin
        case (step)
          3'd0:    return c.pre[7:0];
          3'd1:    return {2'b00, c.mode, c.pre[11:8]};
          3'd2:    return c.addr[7:0];
          3'd3:    return c.addr[15:8];
          3'd4:    return {7'b0, c.addr[16]};
          3'd5:    return {6'b0, shadow};
          default: return 8'h00;
        endcase
      end
      OP_VOLUME:  return c.vol;
      OP_LOOPCFG: return {6'b0, shadow};
      default:    return 8'h00;
    endcase
  endfunction

  top_state_e state_q, state_d;
  cmd_t       cmd_q, cmd_d, cmd_in;
  logic [2:0] step_q, step_d, last_step;
  logic [1:0] shadow_q, shadow_d, shadow_in;
  logic       live_q, live_d;
  logic       start, bus_done;
  logic [3:0] wr_reg;
  logic [7:0] wr_data;

  always_comb begin
    cmd_in = '{op: op_e'(cmd_op), ch: cmd_ch, addr: cmd_addr, pre: cmd_pre,
               mode: cmd_mode, loop: cmd_loop, vol: cmd_vol};
    // The shadow is updated before reg13 goes out, so the first write already sees it.
    shadow_in = shadow_q;
    if (cmd_in.op == OP_PLAY || cmd_in.op == OP_LOOPCFG) shadow_in[cmd_in.ch] = cmd_in.loop;
    last_step = (cmd_q.op == OP_PLAY) ? 3'd6 : 3'd0;

    state_d   = state_q;
    cmd_d     = cmd_q;
    step_d    = step_q;
    shadow_d  = shadow_q;
    live_d    = 1'b1;
    start     = 1'b0;
    wr_reg    = step_reg(cmd_q, step_q + 3'd1);
    wr_data   = step_data(cmd_q, step_q + 3'd1, shadow_q);
    cmd_ready = live_q && (state_q == TOP_IDLE);
    busy      = (state_q != TOP_IDLE);

    case (state_q)
      TOP_IDLE: if (cmd_valid && cmd_ready) begin
        cmd_d    = cmd_in;
        shadow_d = shadow_in;
        step_d   = 3'd0;
        if (cmd_in.op == OP_RSVD) begin
          state_d = TOP_NOP;
        end else begin
          state_d = TOP_RUN;
          start   = 1'b1;
          wr_reg  = step_reg(cmd_in, 3'd0);
          wr_data = step_data(cmd_in, 3'd0, shadow_in);
        end
      end
      TOP_RUN: if (bus_done) begin
        if (step_q == last_step) begin
          state_d = TOP_IDLE;
        end else begin
          step_d = step_q + 3'd1;
          start  = 1'b1;
        end
      end
      default: state_d = TOP_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRES) begin
      state_q  <= TOP_IDLE;
      cmd_q    <= '0;
      step_q   <= 3'd0;
      shadow_q <= 2'b00;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      step_q   <= step_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  k007232_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_bus (
    .clk    (CLK),
    .nres   (NRES),
    .ce     (ce),
    .start  (start),
    .reg_idx(wr_reg),
    .data   (wr_data),
    .done   (bus_done),
    .dacs   (DACS),
    .ab     (AB),
    .db_out (DB_OUT),
    .db_oe  (DB_OE)
  );

endmodule
